// File: rtl/down_timer.sv
// Loadable N-bit down-counter with start/pause control, a one-shot or periodic
// terminal count, and a single-cycle done pulse on each terminal event.
module down_timer #(
  parameter int N = 4
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         load,
  input  logic [N-1:0] load_val,
  input  logic         start,
  input  logic         pause,
  input  logic         auto_reload,
  output logic [N-1:0] q,
  output logic         busy,
  output logic         done
);

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    PAUSED,
    DONE
  } stateType;

  localparam logic [N-1:0] ZERO = '0;
  localparam logic [N-1:0] ONE  = {{(N-1){1'b0}}, 1'b1};

  stateType     state;
  logic [N-1:0] reloadVal;

  // Priority is reset, then load, then whatever the current state does with
  // start/pause; done defaults low so it can only pulse on a terminal edge.
  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= IDLE;
      q         <= ZERO;
      reloadVal <= ZERO;
      done      <= 1'b0;
    end else if (load) begin
      state     <= IDLE;
      q         <= load_val;
      reloadVal <= load_val;
      done      <= 1'b0;
    end else begin
      done <= 1'b0;
      unique case (state)
        IDLE: begin
          if (start && (q != ZERO)) begin
            state <= RUN;
          end
        end
        DONE: begin
          if (start && (reloadVal != ZERO)) begin
            q     <= reloadVal;
            state <= RUN;
          end
        end
        RUN: begin
          if (pause) begin
            state <= PAUSED;
          end else if (q > ONE) begin
            q <= q - ONE;
          end else if (auto_reload) begin
            q    <= reloadVal;
            done <= 1'b1;
          end else begin
            q     <= ZERO;
            done  <= 1'b1;
            state <= DONE;
          end
        end
        PAUSED: begin
          if (!pause) begin
            state <= RUN;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign busy = (state == RUN) || (state == PAUSED);

endmodule

// File: tb/tb_down_timer.sv
// Directed and randomized checks of down_timer (N=4) against a behavioural
// reference model of the timer's rules.
module tb_down_timer;

  logic       clock;
  logic       reset;
  logic       load;
  logic [3:0] loadVal;
  logic       start;
  logic       pause;
  logic       autoReload;
  logic [3:0] q;
  logic       busy;
  logic       done;

  int checks;
  int failures;

  // Reference model: mode is 0 idle, 1 counting, 2 held, 3 finished.
  int mMode;
  int mCount;
  int mReload;
  int mDone;
  int donePulses;

  down_timer #(.N(4)) dut (
    .clk        (clock),
    .reset      (reset),
    .load       (load),
    .load_val   (loadVal),
    .start      (start),
    .pause      (pause),
    .auto_reload(autoReload),
    .q          (q),
    .busy       (busy),
    .done       (done)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  // Drives one edge worth of inputs, advances the model on that edge and
  // returns on the following falling edge where outputs are stable.
  task automatic applyStimulus(input logic r, input logic l, input int lv,
                               input logic s, input logic p, input logic a);
    reset      = r;
    load       = l;
    loadVal    = lv[3:0];
    start      = s;
    pause      = p;
    autoReload = a;
    @(posedge clock);
    if (r) begin
      mMode = 0; mCount = 0; mReload = 0; mDone = 0;
    end else if (l) begin
      mMode = 0; mCount = lv % 16; mReload = lv % 16; mDone = 0;
    end else begin
      mDone = 0;
      if (mMode == 0) begin
        if (s && mCount != 0) mMode = 1;
      end else if (mMode == 3) begin
        if (s && mReload != 0) begin
          mCount = mReload;
          mMode  = 1;
        end
      end else if (mMode == 2) begin
        if (!p) mMode = 1;
      end else begin
        if (p) mMode = 2;
        else if (mCount >= 2) mCount = mCount - 1;
        else begin
          mDone = 1;
          if (a) mCount = mReload;
          else begin
            mCount = 0;
            mMode  = 3;
          end
        end
      end
    end
    @(negedge clock);
    if (done === 1'b1) donePulses++;
  endtask

  task automatic checkOutput(input string tag);
    logic expBusy;
    expBusy = (mMode == 1) || (mMode == 2);
    checks++;
    assert (q === mCount[3:0]) else begin
      failures++;
      $error("[TB] FAIL %s.q observed=%0d expected=%0d", tag, q, mCount);
    end
    checks++;
    assert (busy === expBusy) else begin
      failures++;
      $error("[TB] FAIL %s.busy observed=%b expected=%b", tag, busy, expBusy);
    end
    checks++;
    assert (done === mDone[0]) else begin
      failures++;
      $error("[TB] FAIL %s.done observed=%b expected=%b", tag, done, mDone[0]);
    end
  endtask

  task automatic checkValue(input string tag, input int observed, input int expected);
    checks++;
    assert (observed === expected) else begin
      failures++;
      $error("[TB] FAIL %s observed=%0d expected=%0d", tag, observed, expected);
    end
  endtask

  initial begin
    checks = 0; failures = 0; donePulses = 0;
    mMode = 0; mCount = 0; mReload = 0; mDone = 0;
    reset = 1'b1; load = 1'b0; loadVal = 4'd0;
    start = 1'b0; pause = 1'b0; autoReload = 1'b0;
    @(negedge clock);

    // Reset held two cycles.
    applyStimulus(1, 0, 0, 0, 0, 0);
    applyStimulus(1, 0, 0, 0, 0, 0);
    checkOutput("reset");
    checkValue("reset_q", int'(q), 0);

    // Start from q == 0 is ignored.
    applyStimulus(0, 0, 0, 1, 0, 0);
    checkOutput("start_zero");
    checkValue("start_zero_busy", int'(busy), 0);

    // One-shot from 3: 3,3,2,1,0 with done only at 0.
    applyStimulus(0, 1, 3, 0, 0, 0);
    checkOutput("load3");
    applyStimulus(0, 0, 0, 1, 0, 0);
    checkOutput("start3");
    checkValue("start3_q", int'(q), 3);
    applyStimulus(0, 0, 0, 0, 0, 0);
    checkValue("seq_q2", int'(q), 2);
    applyStimulus(0, 0, 0, 0, 0, 0);
    checkValue("seq_q1", int'(q), 1);
    checkValue("seq_done1_low", int'(done), 0);
    applyStimulus(0, 0, 0, 0, 0, 0);
    checkOutput("seq_end");
    checkValue("seq_q0", int'(q), 0);
    checkValue("seq_done", int'(done), 1);
    checkValue("seq_busy", int'(busy), 0);
    applyStimulus(0, 0, 0, 0, 0, 0);
    checkOutput("done_hold");
    checkValue("done_pulse_once", int'(done), 0);

    // Restart from DONE reloads the stored value.
    applyStimulus(0, 0, 0, 1, 0, 0);
    checkOutput("restart");
    checkValue("restart_q", int'(q), 3);

    // Full-scale count with no wrap and a single done pulse.
    applyStimulus(0, 1, 15, 0, 0, 0);
    applyStimulus(0, 0, 0, 1, 0, 0);
    donePulses = 0;
    for (int i = 0; i < 20; i++) begin
      applyStimulus(0, 0, 0, 0, 0, 0);
      checkOutput("full");
    end
    checkValue("full_q", int'(q), 0);
    checkValue("full_pulses", donePulses, 1);

    // Periodic mode with reload 2.
    applyStimulus(0, 1, 2, 0, 0, 1);
    applyStimulus(0, 0, 0, 1, 0, 1);
    donePulses = 0;
    for (int i = 0; i < 8; i++) begin
      applyStimulus(0, 0, 0, 0, 0, 1);
      checkOutput("periodic");
      checkValue("periodic_q", int'(q), (i % 2 == 0) ? 1 : 2);
      checkValue("periodic_done", int'(done), (i % 2 == 0) ? 0 : 1);
    end
    checkValue("periodic_pulses", donePulses, 4);

    // Pause at 5, with a start during the hold that must be ignored.
    applyStimulus(0, 1, 8, 0, 0, 0);
    applyStimulus(0, 0, 0, 1, 0, 0);
    for (int i = 0; i < 3; i++) applyStimulus(0, 0, 0, 0, 0, 0);
    checkValue("pre_pause_q", int'(q), 5);
    applyStimulus(0, 0, 0, 0, 1, 0);
    checkOutput("pause1");
    applyStimulus(0, 0, 0, 1, 1, 0);
    checkOutput("pause_start");
    applyStimulus(0, 0, 0, 0, 1, 0);
    checkValue("pause_q", int'(q), 5);
    checkValue("pause_busy", int'(busy), 1);
    applyStimulus(0, 0, 0, 0, 0, 0);
    checkValue("resume_q", int'(q), 5);
    applyStimulus(0, 0, 0, 0, 0, 0);
    checkValue("resume_dec", int'(q), 4);

    // Reset mid-run, then load beating start on the same edge.
    applyStimulus(0, 1, 9, 0, 0, 0);
    applyStimulus(0, 0, 0, 1, 0, 0);
    for (int i = 0; i < 3; i++) applyStimulus(0, 0, 0, 0, 0, 0);
    checkValue("pre_reset_q", int'(q), 6);
    applyStimulus(1, 0, 0, 0, 0, 0);
    checkOutput("mid_reset");
    checkValue("mid_reset_done", int'(done), 0);
    applyStimulus(0, 1, 7, 1, 0, 0);
    checkOutput("load_vs_start");
    checkValue("load_vs_start_q", int'(q), 7);
    checkValue("load_vs_start_busy", int'(busy), 0);

    // Randomized traffic against the model.
    for (int i = 0; i < 400; i++) begin
      logic r, l, s, p, a;
      int lv;
      r  = ($urandom_range(0, 39) == 0);
      l  = ($urandom_range(0, 11) == 0);
      s  = ($urandom_range(0, 4) == 0) && (mMode != 1);
      p  = ($urandom_range(0, 5) == 0);
      a  = $urandom_range(0, 1) == 1;
      lv = $urandom_range(0, 15);
      applyStimulus(r, l, lv, s, p, a);
      checkOutput("random");
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/down_timer.md
DOWN_TIMER -- requirements
Module: down_timer

Interface
REQ-001 SHALL have parameter N, default 4, giving count width in bits (N >= 2).
REQ-002 SHALL have port clk  input  1  sole clock; all state changes on its rising edge.
REQ-003 SHALL have port reset  input  1  synchronous, active-high reset, sampled on rising clk.
REQ-004 SHALL have port load  input  1  capture load_val into count and reload register.
REQ-005 SHALL have port load_val  input  N  load value, unsigned.
REQ-006 SHALL have port start  input  1  begin countdown from IDLE or DONE.
REQ-007 SHALL have port pause  input  1  level hold while running.
REQ-008 SHALL have port auto_reload  input  1  periodic mode select, sampled at terminal count.
REQ-009 SHALL have port q  output  N  current count, registered.
REQ-010 SHALL have port busy  output  1  high in RUN or PAUSED.
REQ-011 SHALL have port done  output  1  one-cycle terminal-count pulse, registered.

Function
REQ-012 SHALL implement FSM states IDLE, RUN, PAUSED, DONE.
REQ-013 SHALL apply control priority per edge as reset > load > start > pause.
REQ-014 On load, in any state: q <= load_val, reload <= load_val, state -> IDLE, done <= 0; a running count is aborted.
REQ-015 In IDLE with start=1 and q != 0: state -> RUN; q holds on that edge, with no decrement.
REQ-016 In IDLE, start=1 with q == 0 SHALL be ignored.
REQ-017 In DONE with start=1 and reload != 0: q <= reload, state -> RUN; if reload == 0, start is ignored.
REQ-018 In RUN with pause=0 and q > 1: q <= q-1 each edge.
REQ-019 In RUN, pause=0, q == 1, auto_reload=0: q <= 0, done <= 1, state -> DONE.
REQ-020 In RUN, pause=0, q == 1, auto_reload=1: q <= reload, done <= 1, state stays RUN; period = reload cycles.
REQ-021 In RUN with pause=1: state -> PAUSED, q holds.
REQ-022 In PAUSED: q holds while pause=1; when pause=0, state -> RUN with no decrement on that edge.
REQ-023 In PAUSED, start SHALL be ignored.
REQ-024 done SHALL be 0 on every edge except those named in REQ-019 and REQ-020, giving at most one cycle high per terminal event.
REQ-025 q SHALL never wrap below 0; RUN is entered only with q != 0.
REQ-026 busy SHALL be decoded from registered state: 1 iff state is RUN or PAUSED.
REQ-027 In IDLE and DONE without load or start, q SHALL hold its value.

Reset
REQ-028 On reset=1 at an edge: q=0, reload=0, state=IDLE, done=0, busy=0, regardless of state or other inputs.
REQ-029 Reset asserted mid-RUN or mid-PAUSED SHALL abort the count with no done pulse.
REQ-030 Outputs SHALL be defined (non-X) from the first edge with reset=1.

Verification (N=4)
REQ-031 Reset held 2 cycles -> q=0000, busy=0, done=0.
REQ-032 load 3; start -> q sequence 3,3,2,1,0; done=1 only in the cycle q=0; then DONE, busy=0.
REQ-033 load 15, auto_reload=0, start, 20 cycles -> q reaches 0 after 15 decrements and stays 0 (no wrap to 15); exactly one done pulse.
REQ-034 load 2, auto_reload=1, start -> q 2,1,2,1,...; done pulses on every edge where q returns to 2; busy stays 1.
REQ-035 Running at q=5, pause for 3 cycles -> q=5 and busy=1 throughout; one resume cycle at 5; then 4.
REQ-036 Reset at q=6 mid-run -> next edge q=0, IDLE, no done; load=1 with start=1 on the same edge -> load wins, state IDLE, q=load_val.
